// File: rtl/decode_stage_hazard.sv
// Decode stage with integrated ID/EX register, bypassed register file and
// load-use bubble insertion; back-pressures fetch through out_ready.
module decode_stage_hazard #(
  parameter int unsigned XLEN        = 32,
  parameter int unsigned REG_ADDR_W  = 5,
  parameter int unsigned STALL_CNT_W = 16
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  input  logic [31:0]            in_instruction,
  input  logic [XLEN-1:0]        in_PC,
  input  logic                   in_flush,
  input  logic                   in_ex_ready,
  input  logic                   in_write_enable,
  input  logic [REG_ADDR_W-1:0]  in_write_reg,
  input  logic [XLEN-1:0]        in_write_data,
  output logic                   out_ready,
  output logic                   out_valid,
  output logic                   out_alu_src,
  output logic                   out_mem_write,
  output logic                   out_mem_read,
  output logic                   out_branch,
  output logic                   out_mem_to_reg,
  output logic                   out_reg_write,
  output logic [2:0]             out_alu_op,
  output logic [REG_ADDR_W-1:0]  out_rs1,
  output logic [REG_ADDR_W-1:0]  out_rs2,
  output logic [REG_ADDR_W-1:0]  out_rd,
  output logic [XLEN-1:0]        out_data_a,
  output logic [XLEN-1:0]        out_data_b,
  output logic [XLEN-1:0]        out_immediate,
  output logic [XLEN-1:0]        out_PC,
  output logic [31:0]            out_instruction,
  output logic [6:0]             out_funct7,
  output logic [2:0]             out_funct3,
  output logic [6:0]             out_opcode,
  output logic [STALL_CNT_W-1:0] out_stall_count
);

  localparam int unsigned NREGS = 2 ** REG_ADDR_W;

  typedef enum logic [6:0] {
    OP_R      = 7'b0110011,
    OP_IALU   = 7'b0010011,
    OP_LOAD   = 7'b0000011,
    OP_STORE  = 7'b0100011,
    OP_BRANCH = 7'b1100011,
    OP_JALR   = 7'b1100111,
    OP_JAL    = 7'b1101111,
    OP_LUI    = 7'b0110111,
    OP_AUIPC  = 7'b0010111
  } opcode_e;

  typedef struct packed {
    logic                  valid;
    logic                  alu_src;
    logic                  mem_write;
    logic                  mem_read;
    logic                  branch;
    logic                  mem_to_reg;
    logic                  reg_write;
    logic [2:0]            alu_op;
    logic [REG_ADDR_W-1:0] rs1;
    logic [REG_ADDR_W-1:0] rs2;
    logic [REG_ADDR_W-1:0] rd;
    logic [XLEN-1:0]       data_a;
    logic [XLEN-1:0]       data_b;
    logic [XLEN-1:0]       imm;
    logic [XLEN-1:0]       pc;
    logic [31:0]           instr;
  } idex_t;

  logic [XLEN-1:0]        rf_q [NREGS];
  idex_t                  idex_q, idex_d, dec;
  logic [STALL_CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic                   use_rs1, use_rs2, hazard;
  logic [31:0]            imm32;
  logic [31:0]            ins;

  assign ins = in_instruction;

  always_comb begin
    dec     = '0;
    use_rs1 = 1'b0;
    use_rs2 = 1'b0;
    imm32   = '0;
    hazard  = 1'b0;
    idex_d  = idex_q;
    stall_cnt_d = stall_cnt_q;

    dec.valid = 1'b1;
    dec.rs1   = REG_ADDR_W'(ins[19:15]);
    dec.rs2   = REG_ADDR_W'(ins[24:20]);
    dec.rd    = REG_ADDR_W'(ins[11:7]);
    dec.pc    = in_PC;
    dec.instr = ins;

    case (opcode_e'(ins[6:0]))
      OP_R: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        dec.reg_write = 1'b1; dec.alu_op = 3'b010;
      end
      OP_IALU: begin
        use_rs1 = 1'b1;
        dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu_op = 3'b011;
        imm32 = {{20{ins[31]}}, ins[31:20]};
      end
      OP_LOAD: begin
        use_rs1 = 1'b1;
        dec.alu_src = 1'b1; dec.mem_read = 1'b1; dec.mem_to_reg = 1'b1;
        dec.reg_write = 1'b1; dec.alu_op = 3'b000;
        imm32 = {{20{ins[31]}}, ins[31:20]};
      end
      OP_STORE: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        dec.alu_src = 1'b1; dec.mem_write = 1'b1; dec.alu_op = 3'b000;
        imm32 = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      end
      OP_BRANCH: begin
        use_rs1 = 1'b1; use_rs2 = 1'b1;
        dec.branch = 1'b1; dec.alu_op = 3'b001;
        imm32 = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      end
      OP_JALR: begin
        use_rs1 = 1'b1;
        dec.alu_src = 1'b1; dec.branch = 1'b1; dec.reg_write = 1'b1; dec.alu_op = 3'b100;
        imm32 = {{20{ins[31]}}, ins[31:20]};
      end
      OP_JAL: begin
        dec.branch = 1'b1; dec.reg_write = 1'b1; dec.alu_op = 3'b100;
        imm32 = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      end
      OP_LUI: begin
        dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu_op = 3'b101;
        imm32 = {ins[31:12], 12'b0};
      end
      OP_AUIPC: begin
        dec.alu_src = 1'b1; dec.reg_write = 1'b1; dec.alu_op = 3'b110;
        imm32 = {ins[31:12], 12'b0};
      end
      default: ;
    endcase
    dec.imm = XLEN'(signed'(imm32));

    // Unused source slots carry 0; used ones see a same-cycle WB write.
    if (use_rs1 && dec.rs1 != '0)
      dec.data_a = (in_write_enable && in_write_reg == dec.rs1) ? in_write_data : rf_q[dec.rs1];
    if (use_rs2 && dec.rs2 != '0)
      dec.data_b = (in_write_enable && in_write_reg == dec.rs2) ? in_write_data : rf_q[dec.rs2];

    hazard = idex_q.valid && idex_q.mem_read && (idex_q.rd != '0) && in_valid &&
             ((use_rs1 && dec.rs1 == idex_q.rd) || (use_rs2 && dec.rs2 == idex_q.rd));

    if (in_ex_ready) begin
      if (in_flush) begin
        idex_d = '0;
      end else if (hazard) begin
        idex_d = '0;
        if (stall_cnt_q != '1) stall_cnt_d = stall_cnt_q + STALL_CNT_W'(1);
      end else if (!in_valid) begin
        idex_d = '0;
      end else begin
        idex_d = dec;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idex_q      <= '0;
      stall_cnt_q <= '0;
    end else begin
      idex_q      <= idex_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int unsigned i = 0; i < NREGS; i++) rf_q[i] <= '0;
    end else if (in_write_enable && in_write_reg != '0) begin
      rf_q[in_write_reg] <= in_write_data;
    end
  end

  assign out_ready       = in_ex_ready && (in_flush || !hazard);
  assign out_valid       = idex_q.valid;
  assign out_alu_src     = idex_q.alu_src;
  assign out_mem_write   = idex_q.mem_write;
  assign out_mem_read    = idex_q.mem_read;
  assign out_branch      = idex_q.branch;
  assign out_mem_to_reg  = idex_q.mem_to_reg;
  assign out_reg_write   = idex_q.reg_write;
  assign out_alu_op      = idex_q.alu_op;
  assign out_rs1         = idex_q.rs1;
  assign out_rs2         = idex_q.rs2;
  assign out_rd          = idex_q.rd;
  assign out_data_a      = idex_q.data_a;
  assign out_data_b      = idex_q.data_b;
  assign out_immediate   = idex_q.imm;
  assign out_PC          = idex_q.pc;
  assign out_instruction = idex_q.instr;
  assign out_funct7      = idex_q.instr[31:25];
  assign out_funct3      = idex_q.instr[14:12];
  assign out_opcode      = idex_q.instr[6:0];
  assign out_stall_count = stall_cnt_q;

endmodule

// File: doc/decode_stage_hazard.md
# decode_stage_hazard

Parametrised decode stage with an integrated ID/EX pipeline register, a register file with write-back bypass, and load-use hazard handling. It sits between the IF/ID register and the execute stage. It decodes the instruction, reads operands and generates control signals. It then registers everything for EX, inserting bubbles on load-use hazards, flushes or empty input, and back-pressures fetch through a ready signal.

## Interface
Parameters:
- XLEN, 32, data and PC width; immediates are sign-extended from 32 bits to XLEN
- REG_ADDR_W, 5, register index width; the file holds 2**REG_ADDR_W registers, and x0 is hardwired to zero
- STALL_CNT_W, 16, width of the load-use stall counter

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in_valid  in  1  IF/ID holds a valid instruction
- in_instruction  in  32  instruction from IF/ID
- in_PC  in  XLEN  PC of in_instruction
- in_flush  in  1  branch/jump redirect; kill the instruction currently in decode
- in_ex_ready  in  1  EX can accept a new ID/EX entry this cycle
- in_write_enable  in  1  WB register write strobe
- in_write_reg  in  REG_ADDR_W  WB destination
- in_write_data  in  XLEN  WB data
- out_ready  out  1  decode consumes in_instruction this cycle; fetch holds IF/ID when 0
- out_valid  out  1  ID/EX entry is a real instruction
- out_alu_src, out_mem_write, out_mem_read, out_branch, out_mem_to_reg, out_reg_write  out  1 each  registered control bits
- out_alu_op  out  3  registered ALU op
- out_rs1, out_rs2, out_rd  out  REG_ADDR_W  registered register indices
- out_data_a, out_data_b  out  XLEN  registered operands
- out_immediate, out_PC  out  XLEN  registered immediate and PC
- out_instruction  out  32  registered instruction
- out_funct7 / out_funct3 / out_opcode  out  7 / 3 / 7  registered fields
- out_stall_count  out  STALL_CNT_W  number of load-use bubbles inserted

## Operation
- Decode and control use the team's existing decoder and control units. Field extraction beyond bit 31 of the immediate is a sign-extension to XLEN.
- Source usage is derived from the opcode:
  - rs1 and rs2: R-type 0110011, store 0100011, branch 1100011.
  - rs1 only: I-ALU 0010011, load 0000011, JALR 1100111.
  - None: LUI, AUIPC, JAL.
- Register file: one write port, written at posedge when in_write_enable is set and in_write_reg is not 0. Two combinational read ports; index 0 always reads 0.
- WB bypass: if in_write_enable is set, in_write_reg equals rs (rs not 0), and that rs is being read, the operand takes in_write_data in the same cycle.
- Load-use hazard condition: out_valid, out_mem_read, out_rd not 0, in_valid, and a used rs equals out_rd.
- ID/EX update priority at each posedge:
  - reset asserted (low): all ID/EX fields, the register file and out_stall_count are cleared to 0.
  - in_ex_ready=0: ID/EX holds.
  - in_flush=1: load a bubble.
  - hazard: load a bubble and increment out_stall_count.
  - in_valid=0: load a bubble.
  - otherwise: load the decoded instruction with out_valid=1.
- Bubble: out_valid=0, and every control, index, data and field output is 0.
- out_ready (combinational) = in_ex_ready AND (in_flush OR NOT hazard). During a flush the instruction is consumed and discarded.
- out_stall_count saturates at all-ones; it never wraps.

## Timing
- Decode to EX latency: 1 cycle. An instruction presented with out_ready=1 appears on the ID/EX outputs after the next posedge.
- A load-use hazard costs exactly 1 bubble. On the following cycle out_mem_read=0, so the hazard clears and the held instruction issues. Its operand is then supplied via EX/MEM forwarding outside this block.
- A WB write and a decode read of the same register in the same cycle return the new value, with no extra stall.
- Reset: outputs go to 0 asynchronously while reset is low, and out_ready follows in_ex_ready. The first real issue is at the first posedge after reset is released.
- Flush coincident with a hazard: the flush wins. A bubble is inserted, the stall counter is not incremented, and out_ready=1.
- in_ex_ready=0 coincident with a flush or hazard: the hold wins, out_ready=0, and nothing changes.

## Test plan
- Reset, then issue addi x1,x0,5 (0x00500093) at PC 0x100. Next cycle: out_valid=1, out_reg_write=1, out_rd=1, out_immediate=5, out_PC=0x100, and out_stall_count=0.
- WB writes x2=0xDEADBEEF while decoding add x3,x2,x2. Required: out_data_a = out_data_b = 0xDEADBEEF one cycle later.
- Issue lw x5,0(x1) followed by add x6,x5,x0. Required:
  - out_ready=0 for 1 cycle, then one bubble (out_valid=0).
  - The add issues on the next cycle.
  - out_stall_count=1.
- Issue lw x5,0(x1) followed by lui x5,0x12345. Required: no stall, out_ready stays 1, and out_stall_count=0.
- Assert in_flush during a load-use hazard. Required: a bubble, out_ready=1, and out_stall_count unchanged. Then hold in_ex_ready=0 for 3 cycles. Required: ID/EX outputs stable and out_ready=0.
- Assert reset low mid-stream with out_valid=1. Required: all outputs are 0 immediately, before the next clock. After release, x1 reads 0.
